rng_capture: RTL and testbench
==============================

# rng_capture

Downstream consumer of the PRNG byte stream. Captures one random byte per user button press and holds it steady for the 7-segment decoders. Keeps a 4-entry history of previous captures and a wrapping capture counter. Sits between the PRNG/mux output and the HEX display path, and replaces the free-running display of the mux output.

## Interface

Parameters
- DEBOUNCE_CYCLES, default 16'd50_000, number of consecutive stable cycles required before the debounced button level changes (1 ms at 50 MHz). Legal range 1..65535.

Ports
- clk, input, 1, single system clock; all state is updated on its rising edge.
- reset, input, 1, synchronous, active-high; sampled on the rising edge of clk.
- rnd_in, input, 8, random byte from the PRNG mux.
- rnd_valid, input, 1, rnd_in is fresh this cycle; single-cycle strobe from the PRNG stage.
- btn_raw, input, 1, asynchronous, bouncy push button; active-high.
- sel, input, 2, history read index; 0 is the newest capture, 3 is the oldest.
- hold_out, output, 8, most recently captured byte; drives the display decoders.
- hist_out, output, 8, history entry selected by sel; combinational read of registered storage.
- cap_count, output, 8, number of captures since reset, modulo 256.
- cap_pulse, output, 1, one-cycle strobe in the cycle after a capture is written.
- armed, output, 1, high while waiting for rnd_valid after a press.

## Operation

- Synchronizer: btn_raw passes through two flops (s1, s2) before any use.
- Debouncer:
  - A 16-bit counter runs while s2 != btn_clean and is cleared whenever s2 == btn_clean.
  - When the counter reaches DEBOUNCE_CYCLES-1 while still mismatched, btn_clean <= s2 and the counter clears.
- Edge detect: press = btn_clean & ~btn_clean_d, where btn_clean_d is btn_clean delayed by one cycle.
- FSM states: IDLE, ARMED, RELEASE.
  - IDLE -> ARMED when press is high.
  - ARMED -> RELEASE in any cycle with rnd_valid=1. The capture happens on that same clock edge.
  - RELEASE -> IDLE when btn_clean=0.
  - A press seen in ARMED or RELEASE is ignored.
- Capture (one edge):
  - hold_out <= rnd_in.
  - hist[3] <= hist[2], hist[2] <= hist[1], hist[1] <= hist[0], hist[0] <= rnd_in.
  - cap_count <= cap_count+1.
  - cap_pulse <= 1.
- cap_count wraps from 255 to 0 with no saturation and no flag.
- hist_out = hist[sel]; hist[0] always equals hold_out.
- armed = (state == ARMED), decoded from the state register.
- rnd_valid outside the ARMED state has no effect.

## Timing

- Reset values: hold_out=0, all hist=0, cap_count=0, cap_pulse=0, armed=0, state=IDLE, s1=s2=0, btn_clean=btn_clean_d=0, debounce counter=0.
- Reset asserted mid-operation (any state, including the capture cycle) wins: every register takes its reset value at that edge and the capture is dropped.
- Button held high through reset release: btn_clean rises after the debounce delay, which produces a press. This is intended.
- btn_raw rising (stable) at cycle 0:
  - s2 is high after 2 edges.
  - btn_clean rises DEBOUNCE_CYCLES edges later.
  - press is high in the following cycle.
  - armed is high the cycle after that.
- Capture latency: rnd_valid high in a cycle where armed=1 gives hold_out/hist/cap_count updated and cap_pulse=1 in the next cycle.
- A rnd_valid in the same cycle as press is not captured, because the state is still IDLE.
- Bounce shorter than DEBOUNCE_CYCLES in either direction never changes btn_clean.
- Release must also be debounced before RELEASE -> IDLE.

## Test plan

All scenarios use DEBOUNCE_CYCLES=4.

1. Reset check: hold reset for 3 cycles with btn_raw=0 and random rnd_in/rnd_valid -> all outputs 0, armed=0.
2. Clean press: btn_raw=1 for 20 cycles, then rnd_valid pulsed with rnd_in=8'hA5 two cycles after armed rises -> hold_out=8'hA5, hist[0]=8'hA5, cap_count=1, cap_pulse high for exactly 1 cycle. Release btn and wait 10 cycles -> state returns to IDLE.
3. Bounce rejection: btn_raw toggles 1,0,1,0 with 2-cycle high pulses -> armed never asserts, cap_count stays 0. Then hold btn_raw=1 -> exactly one capture.
4. History and select: 5 press/capture sequences with bytes 8'h11, 22, 33, 44, 55 -> for sel=0..3, hist_out = 55, 44, 33, 22; cap_count=5.
5. Held button / ignored strobes: hold the button through 3 rnd_valid pulses (8'h01, 02, 03) -> only 8'h01 captured, cap_count +1. rnd_valid pulses while IDLE change nothing.
6. Wrap and mid-operation reset:
   - 256 captures -> cap_count=0, hold_out equals the last captured byte.
   - Assert reset in the same cycle as an armed rnd_valid -> no capture, all outputs 0 next cycle.

Source files
------------

// File: rtl/rng_capture.sv
// -----------------------------------------------------------------------------
// rng_capture
//
// Purpose:
//   Captures one byte from the PRNG stream each time the user presses the
//   push button. The byte is held steady for the 7-segment decoders. A
//   4-entry history of previous captures and a wrapping 8-bit capture
//   counter are also kept.
//
// Ports:
//   clk        - system clock; all state changes on its rising edge
//   reset      - synchronous, active-high reset
//   rnd_in     - random byte from the PRNG mux
//   rnd_valid  - single-cycle strobe marking rnd_in as fresh
//   btn_raw    - asynchronous, bouncy, active-high push button
//   sel        - history read index (0 = newest, 3 = oldest)
//   hold_out   - most recently captured byte
//   hist_out   - history entry selected by sel (combinational read)
//   cap_count  - number of captures since reset, modulo 256
//   cap_pulse  - one-cycle strobe in the cycle after a capture
//   armed      - high while waiting for rnd_valid after a press
// -----------------------------------------------------------------------------
module rng_capture #(
    parameter logic [15:0] DEBOUNCE_CYCLES = 16'd50_000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [7:0] rnd_in,
    input  logic       rnd_valid,
    input  logic       btn_raw,
    input  logic [1:0] sel,
    output logic [7:0] hold_out,
    output logic [7:0] hist_out,
    output logic [7:0] cap_count,
    output logic       cap_pulse,
    output logic       armed
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ARMED   = 2'd1,
        RELEASE = 2'd2
    } state_t;

    logic        s1_q;
    logic        s2_q;
    logic [15:0] db_cnt_q;
    logic [15:0] db_cnt_d;
    logic        btn_clean_q;
    logic        btn_clean_d;
    logic        btn_clean_dly_q;
    logic        press;

    state_t      state_q;
    logic [7:0]  hold_q;
    logic [7:0]  hist_q [4];
    logic [7:0]  cap_count_q;
    logic        cap_pulse_q;

    // Two-flop synchronizer: the button is asynchronous to clk, so nothing
    // downstream may look at btn_raw before it has passed through both flops.
    always_ff @(posedge clk) begin
        if (reset) begin
            s1_q <= 1'b0;
            s2_q <= 1'b0;
        end else begin
            s1_q <= btn_raw;
            s2_q <= s1_q;
        end
    end

    // Debouncer next-state: the counter only runs while the synchronized
    // level disagrees with the clean level. Any cycle of agreement restarts
    // it, so a bounce shorter than DEBOUNCE_CYCLES can never flip btn_clean.
    // The clean level follows s2 on the cycle the counter hits its terminal
    // count, which is DEBOUNCE_CYCLES edges after the mismatch began.
    always_comb begin
        db_cnt_d    = 16'd0;
        btn_clean_d = btn_clean_q;
        if (s2_q != btn_clean_q) begin
            if (db_cnt_q == DEBOUNCE_CYCLES - 16'd1) begin
                btn_clean_d = s2_q;
                db_cnt_d    = 16'd0;
            end else begin
                db_cnt_d    = db_cnt_q + 16'd1;
            end
        end
    end

    // Debouncer state plus the one-cycle delayed copy of the clean level
    // that the rising-edge detector compares against.
    always_ff @(posedge clk) begin
        if (reset) begin
            db_cnt_q        <= 16'd0;
            btn_clean_q     <= 1'b0;
            btn_clean_dly_q <= 1'b0;
        end else begin
            db_cnt_q        <= db_cnt_d;
            btn_clean_q     <= btn_clean_d;
            btn_clean_dly_q <= btn_clean_q;
        end
    end

    // A press is the single cycle in which the debounced level has just
    // risen. A button held through reset release still produces one press
    // once the debounce delay has elapsed.
    assign press = btn_clean_q & ~btn_clean_dly_q;

    // Control FSM and capture datapath. The capture happens on the same
    // edge that moves ARMED -> RELEASE, so exactly one byte is taken per
    // press no matter how many strobes arrive while the button is held.
    // RELEASE waits for the debounced button to drop before re-arming is
    // possible. Reset wins over everything, including a capture edge.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= IDLE;
            hold_q      <= 8'd0;
            cap_count_q <= 8'd0;
            cap_pulse_q <= 1'b0;
            for (int i = 0; i < 4; i++) begin
                hist_q[i] <= 8'd0;
            end
        end else begin
            cap_pulse_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (press) begin
                        state_q <= ARMED;
                    end
                end
                ARMED: begin
                    if (rnd_valid) begin
                        state_q     <= RELEASE;
                        hold_q      <= rnd_in;
                        hist_q[3]   <= hist_q[2];
                        hist_q[2]   <= hist_q[1];
                        hist_q[1]   <= hist_q[0];
                        hist_q[0]   <= rnd_in;
                        cap_count_q <= cap_count_q + 8'd1;
                        cap_pulse_q <= 1'b1;
                    end
                end
                RELEASE: begin
                    if (!btn_clean_q) begin
                        state_q <= IDLE;
                    end
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    // Output decode: everything is taken straight from registers except the
    // history read, which is a plain mux on sel over registered storage.
    assign hold_out  = hold_q;
    assign hist_out  = hist_q[sel];
    assign cap_count = cap_count_q;
    assign cap_pulse = cap_pulse_q;
    assign armed     = (state_q == ARMED);

endmodule

// File: tb/tb_rng_capture.sv
// -----------------------------------------------------------------------------
// tb_rng_capture
//
// Purpose:
//   Self-checking bench for rng_capture with DEBOUNCE_CYCLES = 4. Stimulus
//   tasks drive the button and PRNG strobe with randomized bytes and delays
//   and push every expected capture into a scoreboard queue. A separate
//   monitor pops the queue whenever the DUT raises cap_pulse. The reference
//   model is a plain list of captured bytes (newest first) plus a counter
//   taken modulo 256.
//
// Ports: none (top-level bench).
// -----------------------------------------------------------------------------
module tb_rng_capture;

    localparam logic [15:0] DB  = 16'd4;
    localparam int          DBI = 4;

    logic       clk = 1'b0;
    logic       reset;
    logic [7:0] rnd_in;
    logic       rnd_valid;
    logic       btn_raw;
    logic [1:0] sel;
    logic [7:0] hold_out;
    logic [7:0] hist_out;
    logic [7:0] cap_count;
    logic       cap_pulse;
    logic       armed;

    typedef struct {
        logic [7:0] data;
        logic [7:0] count;
        int         cyc;
    } exp_t;

    exp_t       sbQueue [$];
    int         nCompared   = 0;
    int         nMismatched = 0;
    int         cyc         = 0;
    logic [7:0] modelHist [4];
    int         modelCount;

    // Free-running 10 ns clock.
    always #5 clk = ~clk;

    // Cycle index used to time-stamp expected capture pulses.
    always @(posedge clk) cyc <= cyc + 1;

    rng_capture #(
        .DEBOUNCE_CYCLES(DB)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .rnd_in    (rnd_in),
        .rnd_valid (rnd_valid),
        .btn_raw   (btn_raw),
        .sel       (sel),
        .hold_out  (hold_out),
        .hist_out  (hist_out),
        .cap_count (cap_count),
        .cap_pulse (cap_pulse),
        .armed     (armed)
    );

    // One comparison: counts it and reports a mismatch on a single line.
    task automatic checkOutput(input string name, input logic [31:0] actual,
                               input logic [31:0] expected);
        nCompared++;
        if (actual !== expected) begin
            nMismatched++;
            $display("[TB] FAIL %s: got %0h, expected %0h", name, actual, expected);
        end
    endtask

    // Advance n rising edges and land 1 ns after the last one, so all
    // driving and sampling happens away from the active edge.
    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Reference model: after reset no captures are remembered.
    task automatic modelReset();
        for (int i = 0; i < 4; i++) modelHist[i] = 8'd0;
        modelCount = 0;
        sbQueue.delete();
    endtask

    // Reference model: a capture puts the byte at the front of the history
    // list, drops the oldest, bumps the counter modulo 256, and expects the
    // pulse on the very next cycle.
    task automatic modelCapture(input logic [7:0] data);
        exp_t e;
        for (int i = 3; i > 0; i--) modelHist[i] = modelHist[i-1];
        modelHist[0] = data;
        modelCount   = (modelCount + 1) % 256;
        e.data  = data;
        e.count = 8'(modelCount);
        e.cyc   = cyc + 1;
        sbQueue.push_back(e);
    endtask

    // One-cycle rnd_valid strobe; expectCapture says whether the model
    // considers the DUT armed at this moment.
    task automatic applyStimulus(input logic [7:0] data, input bit expectCapture);
        rnd_in    = data;
        rnd_valid = 1'b1;
        if (expectCapture) modelCapture(data);
        tick(1);
        rnd_valid = 1'b0;
        rnd_in    = 8'($urandom);
    endtask

    // Synchronous reset for n cycles with random PRNG noise on the inputs.
    task automatic doReset(input int n);
        btn_raw = 1'b0;
        reset   = 1'b1;
        modelReset();
        for (int i = 0; i < n; i++) begin
            rnd_in    = 8'($urandom);
            rnd_valid = 1'($urandom);
            tick(1);
        end
        rnd_valid = 1'b0;
        reset     = 1'b0;
    endtask

    // Clean press: two synchronizer edges, DB debounce edges and one edge
    // for the press to reach the state register, so armed is expected to
    // rise exactly DB+3 edges after btn_raw goes high.
    task automatic pressAndArm();
        btn_raw = 1'b1;
        tick(DBI + 2);
        checkOutput("armed_early", armed, 1'b0);
        tick(1);
        checkOutput("armed_rise", armed, 1'b1);
    endtask

    // Clean release, long enough for the debounced fall to return to IDLE.
    task automatic releaseBtn();
        btn_raw = 1'b0;
        tick(DBI + 4);
        checkOutput("armed_after_release", armed, 1'b0);
    endtask

    // Complete press / strobe / release with a random wait before the strobe.
    task automatic captureOnce(input logic [7:0] data, input int preDelay);
        pressAndArm();
        tick(preDelay);
        applyStimulus(data, 1'b1);
        tick(1);
        releaseBtn();
    endtask

    // Full output check against the model, walking sel over all entries.
    task automatic checkAll(input string tag);
        checkOutput({tag, "_hold_out"}, hold_out, modelHist[0]);
        checkOutput({tag, "_cap_count"}, cap_count, 8'(modelCount));
        checkOutput({tag, "_cap_pulse"}, cap_pulse, 1'b0);
        checkOutput({tag, "_armed"}, armed, 1'b0);
        for (int i = 0; i < 4; i++) begin
            sel = 2'(i);
            #1;
            checkOutput($sformatf("%s_hist%0d", tag, i), hist_out, modelHist[i]);
        end
    endtask

    // Scoreboard monitor: on every falling edge, a cap_pulse must match the
    // head of the queue (data, count and cycle), and an expected capture
    // whose cycle has passed without a pulse is reported as missed.
    always @(negedge clk) begin
        if (cap_pulse === 1'b1) begin
            if (sbQueue.size() == 0) begin
                checkOutput("unexpected_cap_pulse", cap_pulse, 1'b0);
            end else begin
                exp_t e;
                e = sbQueue.pop_front();
                checkOutput("sb_cycle", cyc, e.cyc);
                checkOutput("sb_hold_out", hold_out, e.data);
                checkOutput("sb_cap_count", cap_count, e.count);
            end
        end else if (sbQueue.size() > 0 && sbQueue[0].cyc < cyc) begin
            void'(sbQueue.pop_front());
            checkOutput("missed_cap_pulse", cap_pulse, 1'b1);
        end
    end

    // Scenario sequence: reset, clean press, bounce rejection, history,
    // held button, counter wrap and reset during a capture edge.
    initial begin
        reset     = 1'b1;
        rnd_in    = 8'd0;
        rnd_valid = 1'b0;
        btn_raw   = 1'b0;
        sel       = 2'd0;

        doReset(3);
        checkAll("reset");

        pressAndArm();
        tick(2);
        applyStimulus(8'hA5, 1'b1);
        tick(1);
        checkOutput("clean_pulse_width", cap_pulse, 1'b0);
        checkAll("clean_press");
        releaseBtn();

        for (int i = 0; i < 2; i++) begin
            btn_raw = 1'b1;
            tick(2);
            btn_raw = 1'b0;
            tick(2);
        end
        for (int i = 0; i < 10; i++) begin
            tick(1);
            checkOutput("bounce_armed", armed, 1'b0);
        end
        checkOutput("bounce_count", cap_count, 8'(modelCount));
        captureOnce(8'($urandom), $urandom_range(0, 3));
        checkAll("bounce_then_press");

        doReset(2);
        captureOnce(8'h11, 1);
        captureOnce(8'h22, 0);
        captureOnce(8'h33, 2);
        captureOnce(8'h44, 3);
        captureOnce(8'h55, 1);
        checkAll("history");

        pressAndArm();
        tick(1);
        applyStimulus(8'h01, 1'b1);
        tick(2);
        applyStimulus(8'h02, 1'b0);
        tick(2);
        applyStimulus(8'h03, 1'b0);
        tick(2);
        releaseBtn();
        for (int i = 0; i < 3; i++) begin
            tick($urandom_range(0, 3));
            applyStimulus(8'($urandom), 1'b0);
        end
        tick(2);
        checkAll("held_button");

        doReset(2);
        for (int i = 0; i < 256; i++) begin
            captureOnce(8'($urandom), $urandom_range(0, 3));
        end
        checkAll("wrap");

        pressAndArm();
        tick($urandom_range(0, 2));
        rnd_in    = 8'($urandom);
        rnd_valid = 1'b1;
        reset     = 1'b1;
        modelReset();
        tick(1);
        rnd_valid = 1'b0;
        btn_raw   = 1'b0;
        checkAll("midop_reset");
        reset = 1'b0;
        tick(DBI + 4);
        checkAll("after_midop_reset");
        captureOnce(8'($urandom), 1);
        tick(3);
        checkAll("final");

        checkOutput("sb_drain", sbQueue.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
        $finish;
    end

endmodule
